ioc_bus_sequencer: RTL and testbench
====================================

// Module: ioc_bus_sequencer
// PURPOSE
//  Shares the IOC register-access bus between two requesters: A = SPI host decoder, B = internal control logic.
//  Round-robin arbitration; sequences one access at a time onto the per-module bus (cs/ioc/data/fetch/load).
//  Returns read data and an ack per requester.
//  Sits between the requesters and all register modules (smi_ctrl, lvds, sys_ctrl, ...).
// PARAMETERS
//  NUM_MODULES   4  number of register modules; o_cs is one-hot over them
//  MOD_W         2  width of module-select fields (>= clog2(NUM_MODULES))
//  READ_LATENCY  2  cycles waited after fetch pulse before sampling module data (>=1)
// PORTS
//  i_sys_clk    in   1               system clock; all logic on rising edge
//  i_rst        in   1               synchronous reset, active-high
//  i_a_req      in   1               requester A access request (level, held until ack)
//  i_a_wr       in   1               A: 1 = load (write), 0 = fetch (read)
//  i_a_mod      in   MOD_W           A: target module index
//  i_a_ioc      in   5               A: register IOC within module
//  i_a_wdata    in   8               A: write data
//  o_a_ack      out  1               A: one-cycle completion pulse
//  o_a_rdata    out  8               A: read data, valid while o_a_ack=1
//  i_b_*/o_b_*  --   same as A       requester B, identical set of ports
//  o_cs         out  NUM_MODULES     one-hot module select
//  o_ioc        out  5               IOC to modules
//  o_data       out  8               write data to modules
//  o_fetch_cmd  out  1               one-cycle read strobe
//  o_load_cmd   out  1               one-cycle write strobe
//  i_rdata_bus  in   8*NUM_MODULES   module read data, module k at bits [8k+7:8k]
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; last_grant=B, so A wins the first tie.
//  Reset mid-transaction aborts it: no ack, strobes and cs drop on the next cycle.
//  FSM states: IDLE -> SETUP -> STROBE -> WAIT (reads only) -> DONE -> IDLE.
//  IDLE: if any req is high, grant and latch wr/mod/ioc/wdata, then go to SETUP.
//    Arbitration: only one requesting -> grant it.
//    Both requesting -> grant the one != last_grant; update last_grant.
//  SETUP (1 cycle): o_cs[mod]=1, o_ioc and o_data driven from latched fields; no strobes.
//  STROBE (1 cycle): cs/ioc/data held.
//    o_fetch_cmd=1 if read, o_load_cmd=1 if write; never both.
//    Write -> DONE. Read -> WAIT.
//  WAIT: hold cs/ioc/data for READ_LATENCY cycles (counter).
//    On the last WAIT edge, register i_rdata_bus[mod] into the granted requester's o_x_rdata.
//  DONE (1 cycle): o_x_ack=1 for the granted requester; other requester's ack stays 0.
//    cs still asserted; all bus outputs go to 0 on exit.
//  Latency (req seen in IDLE at cycle 0):
//    Write: ack in cycle 3.
//    Read: ack in cycle 3+READ_LATENCY (=5 at default).
//  Throughput: one IDLE cycle between transactions; a waiting requester is granted in the IDLE cycle after DONE.
//  Requester handshake:
//    Deassert req on the edge ending the ack cycle.
//    Fields need only be stable in the cycle req is first seen (they are latched).
//    req dropped mid-transaction is ignored; the access completes and is acked.
//  mod >= NUM_MODULES: o_cs stays all-zero, strobes still pulse, read data returns 0x00, ack is issued.
//  o_a_rdata/o_b_rdata hold their last value outside ack. Write acks do not alter rdata.
//  o_cs is only ever zero or one-hot; o_ioc/o_data are 0 whenever o_cs==0 and not in a transaction.
// TESTING
//  1. A read, mod=0, ioc=0, module returns 0x01 (version) -> fetch pulse in cycle 2; o_a_ack in cycle 5 with o_a_rdata=0x01.
//  2. B write, mod=2, ioc=5, wdata=0xA5 -> o_cs=0100, o_ioc=5, o_data=0xA5 from cycle 1; load pulse in cycle 2 only; o_b_ack in cycle 3.
//  3. A and B req in the same cycle, both held for 2 accesses each -> grants A,B,A,B; never two acks at once; never an overlapping cs.
//  4. A read with mod=3, NUM_MODULES=3 -> o_cs==0 throughout; ack with rdata=0x00.
//  5. i_rst pulsed during WAIT of a read -> no ack; all outputs 0 the next cycle; a subsequent A request completes normally.
//  6. Random req/field stimulus, 10k cycles, vs. a reference model -> strobes exactly 1 cycle; cs one-hot; ack count == grant count.

Source files
------------

// File: rtl/ioc_bus_sequencer_if.sv
// Requester-side handshake ports (A and B) plus the shared per-module register bus.
// The sequencer connects through the master modport; the requester/module side uses the slave modport.
interface ioc_bus_sequencer_if #(
  parameter int NUM_MODULES = 4,
  parameter int MOD_W       = 2
);
  logic                     i_a_req;
  logic                     i_a_wr;
  logic [MOD_W-1:0]         i_a_mod;
  logic [4:0]               i_a_ioc;
  logic [7:0]               i_a_wdata;
  logic                     o_a_ack;
  logic [7:0]               o_a_rdata;

  logic                     i_b_req;
  logic                     i_b_wr;
  logic [MOD_W-1:0]         i_b_mod;
  logic [4:0]               i_b_ioc;
  logic [7:0]               i_b_wdata;
  logic                     o_b_ack;
  logic [7:0]               o_b_rdata;

  logic [NUM_MODULES-1:0]   o_cs;
  logic [4:0]               o_ioc;
  logic [7:0]               o_data;
  logic                     o_fetch_cmd;
  logic                     o_load_cmd;
  logic [8*NUM_MODULES-1:0] i_rdata_bus;

  modport master (
    input  i_a_req, i_a_wr, i_a_mod, i_a_ioc, i_a_wdata,
    output o_a_ack, o_a_rdata,
    input  i_b_req, i_b_wr, i_b_mod, i_b_ioc, i_b_wdata,
    output o_b_ack, o_b_rdata,
    output o_cs, o_ioc, o_data, o_fetch_cmd, o_load_cmd,
    input  i_rdata_bus
  );

  modport slave (
    output i_a_req, i_a_wr, i_a_mod, i_a_ioc, i_a_wdata,
    input  o_a_ack, o_a_rdata,
    output i_b_req, i_b_wr, i_b_mod, i_b_ioc, i_b_wdata,
    input  o_b_ack, o_b_rdata,
    input  o_cs, o_ioc, o_data, o_fetch_cmd, o_load_cmd,
    output i_rdata_bus
  );
endinterface

// File: rtl/ioc_bus_sequencer.sv
// Round-robin sequencer sharing the IOC register bus between requesters A and B.
// One access at a time: IDLE -> SETUP -> STROBE -> (WAIT x READ_LATENCY for reads) -> DONE.
module ioc_bus_sequencer #(
  parameter int NUM_MODULES  = 4,
  parameter int MOD_W        = 2,
  parameter int READ_LATENCY = 2
) (
  input  logic                i_sys_clk,
  input  logic                i_rst,
  ioc_bus_sequencer_if.master bus
);

  localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_WAIT,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic             grant_b_q, grant_b_d;
  logic             last_b_q, last_b_d;
  logic             wr_q, wr_d;
  logic [MOD_W-1:0] mod_q, mod_d;
  logic [4:0]       ioc_q, ioc_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       a_rdata_q, a_rdata_d;
  logic [7:0]       b_rdata_q, b_rdata_d;

  logic [7:0]       sel_rdata;
  logic             pick_b;

  always_ff @(posedge i_sys_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      grant_b_q <= 1'b0;
      last_b_q  <= 1'b1;
      wr_q      <= 1'b0;
      mod_q     <= '0;
      ioc_q     <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_b_q <= grant_b_d;
      last_b_q  <= last_b_d;
      wr_q      <= wr_d;
      mod_q     <= mod_d;
      ioc_q     <= ioc_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  // Out-of-range module indices match no slice and read back as zero.
  always_comb begin
    sel_rdata = 8'h00;
    for (int k = 0; k < NUM_MODULES; k++) begin
      if (mod_q == MOD_W'(k)) sel_rdata = bus.i_rdata_bus[8*k +: 8];
    end
  end

  // B wins only when A is idle, or when both ask and A was served last.
  assign pick_b = bus.i_b_req && (!bus.i_a_req || !last_b_q);

  always_comb begin
    state_d   = state_q;
    grant_b_d = grant_b_q;
    last_b_d  = last_b_q;
    wr_d      = wr_q;
    mod_d     = mod_q;
    ioc_d     = ioc_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (bus.i_a_req || bus.i_b_req) begin
          grant_b_d = pick_b;
          last_b_d  = pick_b;
          wr_d      = pick_b ? bus.i_b_wr    : bus.i_a_wr;
          mod_d     = pick_b ? bus.i_b_mod   : bus.i_a_mod;
          ioc_d     = pick_b ? bus.i_b_ioc   : bus.i_a_ioc;
          wdata_d   = pick_b ? bus.i_b_wdata : bus.i_a_wdata;
          state_d   = S_SETUP;
        end
      end
      S_SETUP: state_d = S_STROBE;
      S_STROBE: begin
        if (wr_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_WAIT;
          cnt_d   = CNT_W'(READ_LATENCY - 1);
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
          if (grant_b_q) b_rdata_d = sel_rdata;
          else           a_rdata_d = sel_rdata;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.o_cs        = '0;
    bus.o_ioc       = '0;
    bus.o_data      = '0;
    bus.o_fetch_cmd = 1'b0;
    bus.o_load_cmd  = 1'b0;
    bus.o_a_ack     = 1'b0;
    bus.o_b_ack     = 1'b0;
    bus.o_a_rdata   = a_rdata_q;
    bus.o_b_rdata   = b_rdata_q;
    if (state_q != S_IDLE) begin
      for (int k = 0; k < NUM_MODULES; k++) begin
        bus.o_cs[k] = (mod_q == MOD_W'(k));
      end
      bus.o_ioc  = ioc_q;
      bus.o_data = wdata_q;
    end
    if (state_q == S_STROBE) begin
      bus.o_fetch_cmd = !wr_q;
      bus.o_load_cmd  = wr_q;
    end
    if (state_q == S_DONE) begin
      bus.o_a_ack = !grant_b_q;
      bus.o_b_ack = grant_b_q;
    end
  end

endmodule

// File: tb/tb_ioc_bus_sequencer.sv
// Bench for ioc_bus_sequencer: directed latency/arbitration/reset cases plus a random run
// against a transaction-timeline reference model; a 3-module instance covers out-of-range selects.
module tb_ioc_bus_sequencer;
  localparam int NM  = 4;
  localparam int NM3 = 3;
  localparam int MW  = 2;
  localparam int RL  = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ioc_bus_sequencer_if #(.NUM_MODULES(NM),  .MOD_W(MW)) bif  ();
  ioc_bus_sequencer_if #(.NUM_MODULES(NM3), .MOD_W(MW)) bif3 ();

  ioc_bus_sequencer #(.NUM_MODULES(NM), .MOD_W(MW), .READ_LATENCY(RL)) u_dut (
    .i_sys_clk (clk),
    .i_rst     (rst),
    .bus       (bif)
  );

  ioc_bus_sequencer #(.NUM_MODULES(NM3), .MOD_W(MW), .READ_LATENCY(RL)) u_dut3 (
    .i_sys_clk (clk),
    .i_rst     (rst),
    .bus       (bif3)
  );

  int err_cnt = 0;
  int chk_cnt = 0;
  int cyc     = 0;
  bit chk_en  = 1'b0;

  // Reference model: one scheduled access at a time, described by its grant cycle.
  bit             m_busy   = 1'b0;
  bit             m_gb     = 1'b0;
  bit             m_last_b = 1'b1;
  bit             m_wr     = 1'b0;
  int             m_start  = 0;
  logic [MW-1:0]  m_mod    = '0;
  logic [4:0]     m_ioc    = '0;
  logic [7:0]     m_wdata  = '0;
  logic [7:0]     m_rd_a   = '0;
  logic [7:0]     m_rd_b   = '0;
  int             m_grants = 0;
  int             dcnt [2];
  bit             pend [2];
  bit             drop [2];
  bit             no_new   = 1'b0;
  int             obs_acks = 0;
  int             obs_strobes = 0;

  int             base = -1000;
  logic [31:0]    ord;
  int             nack, dbl;
  logic [NM-1:0]  h_cs [64];
  logic [4:0]     h_ioc [64];
  logic [7:0]     h_data [64], h_rda [64], h_rdb [64];
  logic           h_fetch [64], h_load [64], h_acka [64], h_ackb [64];
  logic [NM3-1:0] h3_cs [64];
  logic           h3_fetch [64], h3_acka [64];
  logic [7:0]     h3_rda [64];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic set_side(input int s, input logic req, input logic wr, input logic [MW-1:0] mod,
                          input logic [4:0] ioc, input logic [7:0] wd);
    if (s == 0) begin
      bif.i_a_req = req; bif.i_a_wr = wr; bif.i_a_mod = mod; bif.i_a_ioc = ioc; bif.i_a_wdata = wd;
    end else begin
      bif.i_b_req = req; bif.i_b_wr = wr; bif.i_b_mod = mod; bif.i_b_ioc = ioc; bif.i_b_wdata = wd;
    end
  endtask

  // Inputs for the current cycle are already driven; check at negedge, advance model, move to next cycle.
  task automatic tick();
    int            k, d, rel;
    logic [NM-1:0] e_cs;
    logic [4:0]    e_ioc;
    logic [7:0]    e_data, cap;
    logic          e_fetch, e_load, e_acka, e_ackb;
    @(negedge clk);
    e_cs = '0; e_ioc = '0; e_data = '0;
    e_fetch = 1'b0; e_load = 1'b0; e_acka = 1'b0; e_ackb = 1'b0;
    k = cyc - m_start;
    d = m_wr ? 3 : 3 + RL;
    if (m_busy) begin
      if (int'(m_mod) < NM) e_cs[m_mod] = 1'b1;
      e_ioc   = m_ioc;
      e_data  = m_wdata;
      e_fetch = (k == 2) && !m_wr;
      e_load  = (k == 2) && m_wr;
      e_acka  = (k == d) && !m_gb;
      e_ackb  = (k == d) && m_gb;
    end
    if (chk_en) begin
      chk("cs",        bif.o_cs,        e_cs);
      chk("ioc",       bif.o_ioc,       e_ioc);
      chk("data",      bif.o_data,      e_data);
      chk("fetch",     bif.o_fetch_cmd, e_fetch);
      chk("load",      bif.o_load_cmd,  e_load);
      chk("ack_a",     bif.o_a_ack,     e_acka);
      chk("ack_b",     bif.o_b_ack,     e_ackb);
      chk("rdata_a",   bif.o_a_rdata,   m_rd_a);
      chk("rdata_b",   bif.o_b_rdata,   m_rd_b);
      chk("cs_onehot", $onehot0(bif.o_cs), 1);
    end
    rel = cyc - base;
    if (rel >= 0 && rel < 64) begin
      h_cs[rel] = bif.o_cs;        h_ioc[rel] = bif.o_ioc;        h_data[rel] = bif.o_data;
      h_fetch[rel] = bif.o_fetch_cmd; h_load[rel] = bif.o_load_cmd;
      h_acka[rel] = bif.o_a_ack;   h_ackb[rel] = bif.o_b_ack;
      h_rda[rel] = bif.o_a_rdata;  h_rdb[rel] = bif.o_b_rdata;
      h3_cs[rel] = bif3.o_cs;      h3_fetch[rel] = bif3.o_fetch_cmd;
      h3_acka[rel] = bif3.o_a_ack; h3_rda[rel] = bif3.o_a_rdata;
    end
    if (bif.o_a_ack) begin ord = {ord[30:0], 1'b0}; nack++; obs_acks++; end
    if (bif.o_b_ack) begin ord = {ord[30:0], 1'b1}; nack++; obs_acks++; end
    if (bif.o_a_ack && bif.o_b_ack) dbl++;
    if (bif.o_fetch_cmd || bif.o_load_cmd) obs_strobes++;
    if (rst) begin
      m_busy = 1'b0; m_last_b = 1'b1; m_rd_a = '0; m_rd_b = '0;
      pend[0] = 1'b0; pend[1] = 1'b0; drop[0] = 1'b0; drop[1] = 1'b0;
    end else if (m_busy) begin
      if (!m_wr && k == d - 1) begin
        cap = (int'(m_mod) < NM) ? bif.i_rdata_bus[8*m_mod +: 8] : 8'h00;
        if (m_gb) m_rd_b = cap;
        else      m_rd_a = cap;
      end
      if (k == d) begin
        m_busy = 1'b0;
        dcnt[m_gb]++;
        pend[m_gb] = 1'b0;
      end
    end else if (bif.i_a_req || bif.i_b_req) begin
      m_gb     = bif.i_a_req ? (bif.i_b_req && !m_last_b) : 1'b1;
      m_last_b = m_gb;
      m_busy   = 1'b1;
      m_start  = cyc;
      m_grants++;
      m_wr    = m_gb ? bif.i_b_wr    : bif.i_a_wr;
      m_mod   = m_gb ? bif.i_b_mod   : bif.i_a_mod;
      m_ioc   = m_gb ? bif.i_b_ioc   : bif.i_a_ioc;
      m_wdata = m_gb ? bif.i_b_wdata : bif.i_a_wdata;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_side(0, 0, 0, '0, '0, '0);
    set_side(1, 0, 0, '0, '0, '0);
    bif3.i_a_req = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic drive_rand();
    for (int s = 0; s < 2; s++) begin
      if (!pend[s]) begin
        if (!no_new && $urandom_range(99) < 35) begin
          pend[s] = 1'b1;
          drop[s] = 1'b0;
          set_side(s, 1'b1, 1'($urandom_range(1)), MW'($urandom_range(NM-1)), 5'($urandom), 8'($urandom));
        end else begin
          set_side(s, 1'b0, 1'($urandom_range(1)), MW'($urandom_range(NM-1)), 5'($urandom), 8'($urandom));
        end
      end else if (!drop[s] && m_busy && int'(m_gb) == s && $urandom_range(99) < 15) begin
        // Requester abandons an already-granted access; it must still complete.
        drop[s] = 1'b1;
        set_side(s, 1'b0, 1'($urandom_range(1)), MW'($urandom_range(NM-1)), 5'($urandom), 8'($urandom));
      end
    end
    bif.i_rdata_bus = $urandom();
  endtask

  task automatic run3(input logic [MW-1:0] mod, input logic [NM3-1:0] exp_cs,
                      input logic [7:0] exp_rd, input string tag);
    logic [NM3-1:0] cs_or;
    base = cyc;
    bif3.i_a_req = 1'b1; bif3.i_a_wr = 1'b0; bif3.i_a_mod = mod; bif3.i_a_ioc = 5'h1A;
    repeat (6) tick();
    bif3.i_a_req = 1'b0;
    tick();
    cs_or = '0;
    for (int r = 0; r < 7; r++) cs_or |= h3_cs[r];
    chk({tag, "_cs"},    cs_or,        exp_cs);
    chk({tag, "_fetch"}, h3_fetch[2],  1);
    chk({tag, "_ack"},   h3_acka[5],   1);
    chk({tag, "_rdata"}, h3_rda[5],    exp_rd);
  endtask

  initial begin
    logic any_ack;
    dcnt[0] = 0; dcnt[1] = 0;
    pend[0] = 1'b0; pend[1] = 1'b0; drop[0] = 1'b0; drop[1] = 1'b0;
    bif.i_rdata_bus = 32'h4433_2201;
    bif3.i_a_req = 1'b0; bif3.i_a_wr = 1'b0; bif3.i_a_mod = '0; bif3.i_a_ioc = '0; bif3.i_a_wdata = '0;
    bif3.i_b_req = 1'b0; bif3.i_b_wr = 1'b0; bif3.i_b_mod = '0; bif3.i_b_ioc = '0; bif3.i_b_wdata = '0;
    bif3.i_rdata_bus = 24'h7E7D7C;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_en = 1'b0;
    do_reset();
    chk_en = 1'b1;

    // Read from module 0 (version register) by A
    base = cyc;
    set_side(0, 1, 0, 2'd0, 5'd0, 8'h00);
    repeat (6) tick();
    set_side(0, 0, 0, 2'd0, 5'd0, 8'h00);
    tick();
    chk("rst_cs",     h_cs[0],    0);
    chk("rst_ack_a",  h_acka[0],  0);
    chk("rst_rdata",  h_rda[0],   0);
    chk("t1_cs",      h_cs[1],    4'b0001);
    chk("t1_fetch",   h_fetch[2], 1);
    chk("t1_fetch3",  h_fetch[3], 0);
    chk("t1_ack4",    h_acka[4],  0);
    chk("t1_ack",     h_acka[5],  1);
    chk("t1_rdata",   h_rda[5],   8'h01);

    // Write by B to module 2
    do_reset();
    base = cyc;
    set_side(1, 1, 1, 2'd2, 5'd5, 8'hA5);
    repeat (4) tick();
    set_side(1, 0, 0, 2'd0, 5'd0, 8'h00);
    tick();
    chk("t2_cs",      h_cs[1],    4'b0100);
    chk("t2_ioc",     h_ioc[1],   5'd5);
    chk("t2_data",    h_data[1],  8'hA5);
    chk("t2_load1",   h_load[1],  0);
    chk("t2_load2",   h_load[2],  1);
    chk("t2_load3",   h_load[3],  0);
    chk("t2_fetch2",  h_fetch[2], 0);
    chk("t2_ack_b",   h_ackb[3],  1);
    chk("t2_ack_a",   h_acka[3],  0);

    // Both requesters held for two accesses each
    do_reset();
    ord = '0; nack = 0; dbl = 0; dcnt[0] = 0; dcnt[1] = 0;
    for (int i = 0; i < 40; i++) begin
      set_side(0, dcnt[0] < 2, 0, 2'd1, 5'd3, 8'h00);
      set_side(1, dcnt[1] < 2, 1, 2'd3, 5'd7, 8'h5C);
      tick();
    end
    chk("t3_nack",    nack, 4);
    chk("t3_order",   ord,  32'h5);
    chk("t3_dbl_ack", dbl,  0);
    chk("t3_rdata_a", bif.o_a_rdata, 8'h22);

    // Out-of-range module on a 3-module instance
    run3(2'd1, 3'b010, 8'h7D, "t4_in");
    run3(2'd3, 3'b000, 8'h00, "t4_oor");

    // Reset during WAIT of a read, then a clean retry
    base = cyc;
    set_side(0, 1, 0, 2'd2, 5'd1, 8'h00);
    repeat (3) tick();
    rst = 1'b1;
    set_side(0, 0, 0, 2'd0, 5'd0, 8'h00);
    tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("t5_pre_rdata", h_rda[3], 8'h22);
    chk("t5_pre_cs",    h_cs[3],  4'b0100);
    chk("t5_cs",        h_cs[4],  0);
    chk("t5_ioc",       h_ioc[4], 0);
    chk("t5_strobes",   {h_fetch[4], h_load[4]}, 0);
    chk("t5_rdata",     h_rda[4], 0);
    any_ack = 1'b0;
    for (int r = 3; r < 7; r++) any_ack |= h_acka[r] | h_ackb[r];
    chk("t5_no_ack",    any_ack,  0);
    base = cyc;
    set_side(0, 1, 0, 2'd2, 5'd1, 8'h00);
    repeat (6) tick();
    set_side(0, 0, 0, 2'd0, 5'd0, 8'h00);
    tick();
    chk("t5_retry_ack",   h_acka[5], 1);
    chk("t5_retry_rdata", h_rda[5],  8'h33);

    // Random traffic against the model
    do_reset();
    m_grants = 0; obs_acks = 0; obs_strobes = 0; no_new = 1'b0;
    repeat (10000) begin
      drive_rand();
      tick();
    end
    no_new = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (!m_busy && !pend[0] && !pend[1]) break;
      drive_rand();
      tick();
    end
    chk("rnd_drained",    {m_busy, pend[0], pend[1]}, 0);
    chk("rnd_ack_grant",  obs_acks,    m_grants);
    chk("rnd_strb_grant", obs_strobes, m_grants);
    chk("rnd_activity",   m_grants > 500, 1);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, limit 2000000 time units");
    $fatal(1, "watchdog");
  end

endmodule
